reg_bank_ctrl: RTL

Multi-cycle control unit that sequences the 8×8-bit register bank and its write-data selector. It fetches 16-bit instructions from a registered program ROM and decodes them. It drives the bank's 6-bit select, load-enable, write-source mux, immediate and ALU opcode. It sits between program memory, the external input port and the register bank/ALU datapath of the microprocessor.

---
 rtl/reg_bank_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/reg_bank_ctrl.sv
// reg_bank_ctrl: fetch/decode/execute sequencer for the 8x8 register bank and its write-source mux.
// Define CTRL_SINGLE_STEP_EN to add the Step input and a PAUSE state between instructions.
module reg_bank_ctrl #(
    parameter int PC_W = 8
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            Start,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic            Step,
`endif
    output logic [PC_W-1:0] Pc,
    input  logic [15:0]     Instr,
    input  logic            In_valid,
    output logic            In_ready,
    input  logic            Flag_z,
    output logic [5:0]      B_sel,
    output logic            LE_sel,
    output logic [1:0]      Mux_sel,
    output logic [7:0]      Imm,
    output logic [2:0]      Alu_op,
    output logic            Busy,
    output logic            Halted
);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, WAIT_IN, WB, HALT
`ifdef CTRL_SINGLE_STEP_EN
        , PAUSE
`endif
    } state_t;

`ifdef CTRL_SINGLE_STEP_EN
    localparam state_t NEXT = PAUSE;
`else
    localparam state_t NEXT = FETCH;
`endif

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, pc_inc, target;
    logic [3:0]      op_q, op_d, op_in;
    logic [5:0]      b_sel_q, b_sel_d;
    logic [1:0]      mux_sel_q, mux_sel_d;
    logic [7:0]      imm_q, imm_d;
    logic [2:0]      alu_op_q, alu_op_d;
    logic            le_sel_q, le_sel_d;
    logic            in_ready_q, in_ready_d;
    logic            busy_q, busy_d;
    logic            halted_q, halted_d;
    logic            z_q, z_d;

    assign op_in  = Instr[15:12];
    assign pc_inc = pc_q + PC_W'(1);
    assign target = PC_W'(imm_q);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        op_d      = op_q;
        b_sel_d   = b_sel_q;
        mux_sel_d = mux_sel_q;
        imm_d     = imm_q;
        alu_op_d  = alu_op_q;
        z_d       = z_q;
        case (state_q)
            IDLE, HALT: begin
                if (Start) begin
                    state_d = FETCH;
                    pc_d    = '0;
                end
            end
            FETCH: state_d = DECODE;
            DECODE: begin
                op_d      = op_in;
                b_sel_d   = {Instr[8:6], Instr[11:9]};
                imm_d     = Instr[7:0];
                alu_op_d  = op_in[3] ? op_in[2:0] : 3'd0;
                mux_sel_d = op_in == 4'd1 ? 2'b01 :
                            op_in == 4'd2 ? 2'b11 :
                            op_in == 4'd4 ? 2'b10 : 2'b00;
                case (op_in)
                    4'd1, 4'd2: state_d = WB;
                    4'd4:       state_d = WAIT_IN;
                    4'd5, 4'd6: state_d = EXEC;
                    4'd7:       state_d = HALT;
                    4'd0, 4'd3: begin
                        state_d = NEXT;
                        pc_d    = pc_inc;
                    end
                    default:    state_d = EXEC;
                endcase
            end
            EXEC: begin
                if (op_q[3]) begin
                    state_d = WB;
                end else begin
                    // only JMP (5) and JZ (6) reach here besides ALU ops
                    state_d = NEXT;
                    pc_d    = (op_q == 4'd5 || z_q) ? target : pc_inc;
                end
            end
            WAIT_IN: state_d = In_valid ? WB : WAIT_IN;
            WB: begin
                state_d = NEXT;
                pc_d    = pc_inc;
                z_d     = op_q[3] ? Flag_z : z_q;
            end
`ifdef CTRL_SINGLE_STEP_EN
            PAUSE: state_d = Step ? FETCH : PAUSE;
`endif
            default: state_d = IDLE;
        endcase
        le_sel_d   = state_d == WB;
        in_ready_d = state_d == WAIT_IN;
        busy_d     = !(state_d == IDLE || state_d == HALT);
        halted_d   = state_d == HALT;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            op_q       <= '0;
            b_sel_q    <= '0;
            mux_sel_q  <= '0;
            imm_q      <= '0;
            alu_op_q   <= '0;
            le_sel_q   <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
            z_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            op_q       <= op_d;
            b_sel_q    <= b_sel_d;
            mux_sel_q  <= mux_sel_d;
            imm_q      <= imm_d;
            alu_op_q   <= alu_op_d;
            le_sel_q   <= le_sel_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            halted_q   <= halted_d;
            z_q        <= z_d;
        end
    end

    assign Pc       = pc_q;
    assign B_sel    = b_sel_q;
    assign LE_sel   = le_sel_q;
    assign Mux_sel  = mux_sel_q;
    assign Imm      = imm_q;
    assign Alu_op   = alu_op_q;
    assign In_ready = in_ready_q;
    assign Busy     = busy_q;
    assign Halted   = halted_q;

endmodule
